// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: receive FSM state encoding and default frame geometry.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop rxd sync, bclkx8 edge tick, start/data/parity/stop/break FSM.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 bclkx8,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state, state_nxt;
  logic                 rxd_s;
  logic                 bclk_q;
  logic                 tick;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 shift_en;
  logic                 load;
  logic                 ferr;

`ifdef UART_RX_PARITY_EN
  logic                 par_en;
  logic                 par_bit;
`endif

  sync_2ff #(.RESET_VAL(1'b1)) u_rxd_sync (
    .clk   (sys_clk),
    .rst_n (rst),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign tick    = bclkx8 & ~bclk_q;
  assign rx_busy = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shift_en  = 1'b0;
    load      = 1'b0;
    ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_nxt = ST_START;
            cnt_nxt   = '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt_nxt   = '0;
            bit_nxt   = '0;
            state_nxt = rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt_nxt  = '0;
            shift_en = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt = ST_PARITY;
`else
              state_nxt = ST_STOP;
`endif
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (cnt == FULL_LAST) begin
            cnt_nxt   = '0;
            par_en    = 1'b1;
            state_nxt = ST_STOP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
`else
          state_nxt = ST_IDLE;
`endif
        end
        ST_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt_nxt = '0;
            if (rxd_s) begin
              load      = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              ferr      = 1'b1;
              state_nxt = ST_BREAK;
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_BREAK: begin
          // A held-low line parks here so it cannot look like a fresh start bit.
          if (rxd_s) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // rx_valid is a one-cycle strobe with no back-pressure; rx_data stays stable until the next strobe.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      bclk_q      <= 1'b0;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      bclk_q      <= bclkx8;
      cnt         <= cnt_nxt;
      bit_cnt     <= bit_nxt;
      if (shift_en) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
      if (load) rx_data <= shreg;
      rx_valid    <= load;
      framing_err <= ferr;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= rxd_s;
      parity_err <= load & (^shreg ^ par_bit);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 4800 baud x8 tick generator, directed scenarios plus random frames vs a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  BIT_TICKS     = 8;
  localparam int  BCLK_HALF_CYC = 4;
  localparam real SYS_HALF      = 1627.604;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b0;
  logic       bclkx8  = 1'b0;
  logic       rxd     = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, framing_err, parity_err, rx_busy;

  int errors = 0;
  int checks = 0;

  int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, perr_alone = 0;
  int wide_cnt = 0, hold_viol = 0;
  logic       prev_valid = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int         exp_valid = 0, exp_ferr = 0, exp_perr = 0;
  logic [7:0] exp_data = 8'h00;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .bclkx8      (bclkx8),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .framing_err (framing_err),
    .parity_err  (parity_err),
    .rx_busy     (rx_busy)
  );

  // clock / reset block: sys_clk at 64 x 4800 Hz, bclkx8 = sys_clk / 8 = 8 x 4800 Hz
  initial forever #(SYS_HALF) sys_clk = ~sys_clk;

  int div = 0;
  always @(negedge sys_clk) begin
    div = div + 1;
    if (div == BCLK_HALF_CYC) begin
      div = 0;
      bclkx8 = ~bclkx8;
    end
  end

  initial begin
    #(SYS_HALF * 2.0 * 80000.0);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // output monitor feeding the scoreboard
  always @(negedge sys_clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_data);
    end
    if (framing_err) ferr_cnt++;
    if (parity_err) begin
      perr_cnt++;
      if (!rx_valid) perr_alone++;
    end
    if ((rx_valid && prev_valid) || (framing_err && prev_ferr) || (parity_err && prev_perr))
      wide_cnt++;
    if (rst && !rx_valid && rx_data !== prev_data) hold_viol++;
    prev_valid = rx_valid;
    prev_ferr  = framing_err;
    prev_perr  = parity_err;
    prev_data  = rx_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge bclkx8);
  endtask

  // driver: start bit, data LSB first, optional parity, stop; rxd is left at the stop level
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
    rxd = 1'b0;
    ticks(BIT_TICKS);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      ticks(BIT_TICKS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par;
    ticks(BIT_TICKS);
`else
    if (par === 1'bz) rxd = 1'b1;
`endif
    rxd = stop;
    ticks(BIT_TICKS);
  endtask

  // reference model: what one complete frame should produce
  task automatic model_frame(input logic [7:0] data, input logic stop, input logic par);
    if (stop) begin
      exp_valid++;
      exp_data = data;
      exp_q.push_back(data);
`ifdef UART_RX_PARITY_EN
      if (par != ^data) exp_perr++;
`else
      if (par === 1'bz) exp_perr = exp_perr;
`endif
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_valid_cnt"}, valid_cnt, exp_valid);
    chk({tag, "_ferr_cnt"},  ferr_cnt,  exp_ferr);
    chk({tag, "_perr_cnt"},  perr_cnt,  exp_perr);
    chk({tag, "_rx_data"},   rx_data,   exp_data);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, par;
    logic [7:0] f0;

    repeat (5) @(negedge sys_clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_framing_err", framing_err, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_rx_busy", rx_busy, 1'b0);
    #1 rst = 1'b1;
    ticks(4);
    chk("idle_busy", rx_busy, 1'b0);

    // good frame
    model_frame(8'hA5, 1'b1, ^8'hA5);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    ticks(4);
    check_counts("a5");
    chk("a5_busy", rx_busy, 1'b0);

    // false start: two ticks low, then high
    rxd = 1'b0;
    ticks(2);
    chk("false_start_busy_high", rx_busy, 1'b1);
    rxd = 1'b1;
    ticks(4);
    chk("false_start_busy_low", rx_busy, 1'b0);
    check_counts("false_start");

    // bad stop bit, line held low 20 ticks in total
    model_frame(8'h3C, 1'b0, ^8'h3C);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    ticks(12);
    chk("break_busy_held", rx_busy, 1'b1);
    check_counts("3c_break");
    rxd = 1'b1;
    ticks(4);
    chk("break_release_busy", rx_busy, 1'b0);

`ifdef UART_RX_PARITY_EN
    // wrong parity bit: data still delivered with parity_err alongside
    model_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    ticks(4);
    check_counts("parity_01");
`endif

    // reset in the middle of 0xF0 after four data bits
    f0 = 8'hF0;
    rxd = 1'b0;
    ticks(BIT_TICKS);
    for (int i = 0; i < 4; i++) begin
      rxd = f0[i];
      ticks(BIT_TICKS);
    end
    #1 rst = 1'b0;
    rxd = 1'b1;
    exp_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_rx_valid", rx_valid, 1'b0);
    chk("midrst_framing_err", framing_err, 1'b0);
    chk("midrst_parity_err", parity_err, 1'b0);
    chk("midrst_rx_busy", rx_busy, 1'b0);
    #1 rst = 1'b1;
    ticks(10);
    model_frame(8'h55, 1'b1, ^8'h55);
    send_frame(8'h55, 1'b1, ^8'h55);
    ticks(4);
    check_counts("after_rst_55");

    // back-to-back frames, no idle gap
    model_frame(8'h00, 1'b1, ^8'h00);
    model_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    ticks(4);
    check_counts("b2b");

    // random frames with random stop level, parity errors and gaps
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
`ifndef UART_RX_PARITY_EN
      par  = ^d;
`endif
      model_frame(d, stop, par);
      send_frame(d, stop, par);
      if (!stop) begin
        ticks($urandom_range(0, 10));
        rxd = 1'b1;
        ticks(2);
      end
      ticks($urandom_range(0, 6));
      check_counts($sformatf("rand%0d", n));
    end
    ticks(4);

    // final scoreboard and pulse-shape report
    chk("sb_size", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("sb_word%0d", i), got_q[i], exp_q[i]);
    chk("pulse_width", wide_cnt, 0);
    chk("rx_data_hold", hold_viol, 0);
    chk("perr_without_valid", perr_alone, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, sets the number of data bits per frame (legal range 5-8).
REQ-002 Parameter OVERSAMPLE, default 8, sets the number of bclkx8 ticks per bit period.
REQ-003 Port sys_clk, input, 1 bit: the single system clock; every flop SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port bclkx8, input, 1 bit: 8x baud square wave from the baud rate generator, already in the sys_clk domain.
REQ-006 Port rxd, input, 1 bit: serial line, asynchronous, idle high.
REQ-007 Port rx_data, output, DATA_BITS wide: last received word, LSB first on the line.
REQ-008 Port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-009 Port framing_err, output, 1 bit: one-cycle pulse when the stop bit is sampled as 0.
REQ-010 Port parity_err, output, 1 bit: one-cycle pulse when the parity check fails.
REQ-011 Port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 Sync and tick: rxd SHALL pass through a 2-flop synchronizer, and each rising edge of bclkx8 (registered previous value 0, current value 1) SHALL form a one-sys_clk "tick".
REQ-013 FSM states and transitions: the FSM SHALL have states IDLE, START, DATA, PARITY, STOP and BREAK, and SHALL advance only on ticks.
REQ-014 IDLE: on a tick with synchronized rxd = 0, the FSM SHALL go to START and clear the tick counter.
REQ-015 START: after OVERSAMPLE/2 ticks, the FSM SHALL go to DATA if rxd = 0, otherwise to IDLE (false start, no outputs pulsed).
REQ-016 DATA: the FSM SHALL sample rxd every OVERSAMPLE ticks into a shift register, LSB first, for DATA_BITS samples; it SHALL then go to PARITY if the parity feature is compiled in, otherwise to STOP.
REQ-017 PARITY: the FSM SHALL sample one bit after OVERSAMPLE ticks, then go to STOP.
REQ-018 STOP, good stop bit: after OVERSAMPLE ticks, if rxd = 1 the block SHALL load rx_data and pulse rx_valid, then the FSM SHALL go to IDLE.
REQ-019 STOP, bad stop bit: if rxd = 0 the block SHALL pulse framing_err, SHALL NOT pulse rx_valid and SHALL leave rx_data unchanged, then the FSM SHALL go to BREAK.
REQ-020 BREAK: the FSM SHALL stay in BREAK until a tick samples rxd = 1, then go to IDLE, so a held-low line never retriggers START.
REQ-021 Latency: rx_valid, framing_err and parity_err SHALL assert exactly one sys_clk cycle after the mid-stop-bit tick and SHALL be one cycle wide.
REQ-022 rx_data SHALL hold its value between rx_valid pulses.
REQ-023 Back-to-back frames (a start bit immediately after the stop bit) SHALL be received without loss, since the STOP-to-IDLE transition completes within the first half of the stop bit.
REQ-024 A tick and an output pulse in the same cycle SHALL not interact; output pulses are registered.

Reset
REQ-025 rst = 0 SHALL asynchronously force: FSM = IDLE, counters = 0, shift register = 0, rx_data = 0, rx_valid = 0, framing_err = 0, parity_err = 0, rx_busy = 0, synchronizer flops = 1, bclkx8 edge register = 0.
REQ-026 A reset mid-frame SHALL abort the frame with no output pulse; the first full frame after reset deassertion SHALL be received normally.

Configuration
REQ-027 Macro UART_RX_PARITY_EN: when defined, one even-parity bit follows the data bits; on a mismatch, parity_err SHALL pulse in the same cycle as rx_valid, and rx_data SHALL still update.
REQ-028 Without UART_RX_PARITY_EN: the PARITY state is never entered, and parity_err SHALL be tied to 0.

Structure
REQ-029 Shared package uart_pkg SHALL hold the rx state enum typedef and the default constants for OVERSAMPLE and DATA_BITS.
REQ-030 A sub-module sync_2ff SHALL implement the rxd synchronizer; the edge detect and FSM SHALL live in uart_rx.

Verification
REQ-031 The bench SHALL drive bclkx8 from a behavioural 8x generator at 4800 baud and cover:
- Frame 0xA5 with stop = 1 -> one rx_valid pulse, rx_data = 0xA5, framing_err = 0.
- rxd low for 2 ticks, then high -> no pulses, rx_busy returns to 0 within 4 ticks.
- Frame 0x3C with stop = 0, line held low for 20 ticks -> one framing_err pulse, no rx_valid, rx_busy stays high until rxd = 1.
- UART_RX_PARITY_EN defined, data 0x01 with parity bit 0 -> rx_valid and parity_err pulse together, rx_data = 0x01.
- rst asserted after 4 data bits of 0xF0, then frame 0x55 -> all outputs 0 during reset, then one rx_valid with rx_data = 0x55.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, rx_data = 0x00, then 0xFF.
